cpu_seq4: RTL and testbench

- Instruction sequencer and 4x4-bit register file that sits directly upstream of the registered 4-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads the operand registers.
- Drives the ALU's a/b/cin/alu_sel inputs, waits out the ALU's one-cycle register latency, then writes the ALU result back and updates the carry and zero flags.
- Also supports a load-immediate instruction that bypasses the ALU.

---
 rtl/cpu_seq4_pkg.sv | 33 +++
 rtl/cpu_seq4_if.sv | 32 +++
 rtl/cpu_seq4_reg_file4.sv | 35 +++
 rtl/cpu_seq4.sv | 122 ++++++++++++
 tb/tb_cpu_seq4.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_seq4_pkg.sv
// Shared types and constants for the cpu_seq4 sequencer slice.
// Latency: n/a (types, constants and a field helper only).
// Backpressure: n/a.
package cpu_seq4_pkg;

  localparam int NREGS   = 4;   // general registers; only 4 supported
  localparam int AW      = 2;   // register index width
  localparam int DW      = 4;   // datapath width, must match the ALU
  localparam int SEL_W   = 3;   // ALU select width
  localparam int INSTR_W = 11;  // instruction word width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // ALU-op layout; bit 10 set marks LDI, which reuses rd and puts imm in [3:0]
  typedef struct packed {
    logic             is_ldi;  // [10]
    logic [AW-1:0]    rd;      // [9:8]
    logic [AW-1:0]    rs1;     // [7:6]
    logic [AW-1:0]    rs2;     // [5:4]
    logic [SEL_W-1:0] sel;     // [3:1]
    logic             cin;     // [0]
  } instr_t;

  // LDI immediate overlays the sel/cin fields of the ALU layout
  function automatic logic [DW-1:0] ldi_imm(instr_t i);
    return {i.sel, i.cin};
  endfunction

endpackage

// File: rtl/cpu_seq4_if.sv
// Instruction handshake, ALU drive/return and status/debug bundle.
// Latency: n/a (wiring only).
// Backpressure: instr_valid/instr_ready; the sequencer is the slave side.
interface cpu_seq4_if;
  import cpu_seq4_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [DW-1:0]      alu_a;
  logic [DW-1:0]      alu_b;
  logic               alu_cin;
  logic [SEL_W-1:0]   alu_sel;
  logic [DW-1:0]      alu_result;
  logic               alu_cout;
  logic               done;
  logic               flag_c;
  logic               flag_z;
  logic [AW-1:0]      dbg_addr;
  logic [DW-1:0]      dbg_data;

  modport master (
    output instr, instr_valid, alu_result, alu_cout, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_cin, alu_sel, done, flag_c, flag_z, dbg_data
  );

  modport slave (
    input  instr, instr_valid, alu_result, alu_cout, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_cin, alu_sel, done, flag_c, flag_z, dbg_data
  );

endinterface

// File: rtl/cpu_seq4_reg_file4.sv
// 4x4-bit register file: one synchronous write port, three combinational reads.
// Latency: write visible on read ports the cycle after the write edge.
// Backpressure: none; always accepts a write.
module cpu_seq4_reg_file4
  import cpu_seq4_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] regs [NREGS];

  // Register storage: cleared on reset, one write per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/cpu_seq4.sv
// Instruction sequencer driving a registered 4-bit ALU, with writeback and flags.
// Latency: ALU op accept->writeback 2 edges, LDI 1 edge; done pulses the cycle after.
// Backpressure: instr_ready only in IDLE; one ALU op per 3 cycles, one LDI per 2.
module cpu_seq4
  import cpu_seq4_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  cpu_seq4_if.slave bus
);

  state_t           state, state_nxt;
  instr_t           ins;
  logic             ready, accept, we;
  logic [AW-1:0]    rd_q;
  logic [DW-1:0]    imm_q, wdata, rs1_dat, rs2_dat;
  logic             ldi_q;
  logic [DW-1:0]    alu_a_q, alu_b_q;
  logic [SEL_W-1:0] alu_sel_q;
  logic             alu_cin_q, done_q, flag_c_q, flag_z_q;

  assign ins    = instr_t'(bus.instr);
  assign accept = bus.instr_valid & ready;

  // Operands are read straight from the presented instruction so they can be captured at accept
  cpu_seq4_reg_file4 u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (rd_q),
    .wdata    (wdata),
    .raddr1   (ins.rs1),
    .raddr2   (ins.rs2),
    .dbg_addr (bus.dbg_addr),
    .rdata1   (rs1_dat),
    .rdata2   (rs2_dat),
    .dbg_data (bus.dbg_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state: LDI skips EXEC because it never touches the ALU
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ins.is_ldi ? ST_WB : ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-state outputs: handshake ready and register-file write strobe/data
  always_comb begin
    ready = 1'b0;
    we    = 1'b0;
    wdata = bus.alu_result;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_WB: begin
        we    = 1'b1;
        wdata = ldi_q ? imm_q : bus.alu_result;
      end
      default: ;
    endcase
  end

  // Capture destination, immediate and ALU drive at accept; ALU drive holds otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q      <= '0;
      imm_q     <= '0;
      ldi_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      alu_cin_q <= 1'b0;
    end else if (accept) begin
      rd_q  <= ins.rd;
      ldi_q <= ins.is_ldi;
      if (ins.is_ldi) begin
        imm_q <= ldi_imm(ins);
      end else begin
        alu_a_q   <= rs1_dat;
        alu_b_q   <= rs2_dat;
        alu_sel_q <= ins.sel;
        alu_cin_q <= ins.cin;
      end
    end
  end

  // Flags follow ALU writebacks only; LDI leaves them alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (state == ST_WB && !ldi_q) begin
      flag_c_q <= bus.alu_cout;
      flag_z_q <= (bus.alu_result == '0);
    end
  end

  // Completion pulse for the cycle right after writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= (state == ST_WB);
  end

  assign bus.instr_ready = ready;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.alu_cin     = alu_cin_q;
  assign bus.done        = done_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_z      = flag_z_q;

endmodule

// File: tb/tb_cpu_seq4.sv
// Bench for cpu_seq4 with a behavioural registered ALU and a register-file model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_seq4;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  cpu_seq4_if bus ();

  cpu_seq4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] mregs [4];
  logic       mc, mz;

  // Behavioural ALU: {cout, result}
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel, input logic cin);
    logic [4:0] s;
    case (sel)
      3'd0: s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      3'd1: s = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
      3'd2: s = {1'b0, a & b};
      3'd3: s = {1'b0, a | b};
      3'd4: s = {1'b0, a ^ b};
      3'd5: s = {1'b0, ~a};
      3'd6: s = {a, cin};
      default: s = {1'b0, b};
    endcase
    return s;
  endfunction

  // Registered ALU stand-in, one cycle of latency
  always @(posedge clk) begin
    {bus.alu_cout, bus.alu_result} <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin);
  end

  function automatic logic [10:0] mk_alu(input int rd, input int rs1, input int rs2,
                                          input int sel, input int cin);
    return {1'b0, 2'(rd), 2'(rs1), 2'(rs2), 3'(sel), 1'(cin)};
  endfunction

  function automatic logic [10:0] mk_ldi(input int rd, input int imm);
    return {1'b1, 2'(rd), 4'($urandom), 4'(imm)};
  endfunction

  // Architectural effect of one completed instruction
  task automatic apply(input logic [10:0] w);
    logic [4:0] r;
    if (w[10]) begin
      mregs[w[9:8]] = w[3:0];
    end else begin
      r = alu_fn(mregs[w[7:6]], mregs[w[5:4]], w[3:1], w[0]);
      mregs[w[9:8]] = r[3:0];
      mc = r[4];
      mz = (r[3:0] == 4'd0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 4'd0;
    mc = 1'b0;
    mz = 1'b0;
  endtask

  task automatic read_reg(input int i, output logic [3:0] v);
    bus.dbg_addr = 2'(i);
    #1;
    v = bus.dbg_data;
  endtask

  // Issue one instruction, report ready/ALU drive after accept and edges until done (-1 on timeout)
  task automatic run_instr(input logic [10:0] w, output int lat, output logic rdy_after,
                           output logic [3:0] a_s, output logic [3:0] b_s,
                           output logic [2:0] sel_s, output logic cin_s);
    int n;
    @(negedge clk);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 11'($urandom);
    rdy_after = bus.instr_ready;
    a_s   = bus.alu_a;
    b_s   = bus.alu_b;
    sel_s = bus.alu_sel;
    cin_s = bus.alu_cin;
    lat = 0;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done || n >= 20) lat = -1;
  endtask

  task automatic test_reset();
    logic [3:0] v;
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else passed++;
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {bus.flag_c, bus.flag_z}); else passed++;
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin} !== 12'd0)
      $display("FAIL reset_alu_drive got=%h exp=000", {bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin}); else passed++;
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      checks++; if (v !== 4'd0) $display("FAIL reset_reg%0d got=%h exp=0", i, v); else passed++;
    end
  endtask

  task automatic test_ldi();
    int lat; logic rdy; logic [3:0] a, b, v; logic [2:0] s; logic c;
    run_instr(11'b1_01_0000_0101, lat, rdy, a, b, s, c);
    apply(11'b1_01_0000_0101);
    checks++; if (rdy !== 1'b0) $display("FAIL ldi_busy got=%b exp=0", rdy); else passed++;
    checks++; if (lat !== 1) $display("FAIL ldi_latency got=%0d exp=1", lat); else passed++;
    read_reg(1, v);
    checks++; if (v !== 4'd5) $display("FAIL ldi_r1 got=%h exp=5", v); else passed++;
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b00) $display("FAIL ldi_flags got=%b exp=00", {bus.flag_c, bus.flag_z}); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL ldi_done_width got=%b exp=0", bus.done); else passed++;
  endtask

  task automatic test_add();
    int lat; logic rdy; logic [3:0] a, b, v; logic [2:0] s; logic c;
    logic [10:0] w;
    run_instr(mk_ldi(1, 5), lat, rdy, a, b, s, c); apply(mk_ldi(1, 5));
    run_instr(mk_ldi(2, 3), lat, rdy, a, b, s, c); apply(mk_ldi(2, 3));
    w = mk_alu(3, 1, 2, 0, 0);
    run_instr(w, lat, rdy, a, b, s, c);
    apply(w);
    checks++; if ({a, b} !== 8'h53) $display("FAIL add_operands got=%h exp=53", {a, b}); else passed++;
    checks++; if (lat !== 2) $display("FAIL add_latency got=%0d exp=2", lat); else passed++;
    read_reg(3, v);
    checks++; if (v !== 4'd8) $display("FAIL add_r3 got=%h exp=8", v); else passed++;
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b00) $display("FAIL add_flags got=%b exp=00", {bus.flag_c, bus.flag_z}); else passed++;
  endtask

  task automatic test_wrap();
    int lat; logic rdy; logic [3:0] a, b, v; logic [2:0] s; logic c;
    logic [10:0] w;
    run_instr(mk_ldi(1, 15), lat, rdy, a, b, s, c); apply(mk_ldi(1, 15));
    run_instr(mk_ldi(2, 1), lat, rdy, a, b, s, c);  apply(mk_ldi(2, 1));
    w = mk_alu(0, 1, 2, 0, 0);
    run_instr(w, lat, rdy, a, b, s, c);
    apply(w);
    read_reg(0, v);
    checks++; if (v !== 4'd0) $display("FAIL wrap_r0 got=%h exp=0", v); else passed++;
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b11) $display("FAIL wrap_flags got=%b exp=11", {bus.flag_c, bus.flag_z}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] ops [3];
    int acc [3];
    int k, t;
    logic [3:0] v;
    ops[0] = mk_alu(3, 1, 2, 0, 0);
    ops[1] = mk_alu(0, 3, 1, 0, 1);
    ops[2] = mk_alu(1, 0, 3, 4, 0);
    k = 0; t = 0;
    @(negedge clk);
    bus.instr = ops[0];
    bus.instr_valid = 1'b1;
    while (k < 3 && t < 40) begin
      if (bus.instr_ready) begin
        acc[k] = t;
        apply(ops[k]);
        k++;
      end
      @(negedge clk);
      t++;
      if (k < 3) bus.instr = ops[k];
    end
    bus.instr_valid = 1'b0;
    t = 0;
    while (!bus.done && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++; if (k !== 3) $display("FAIL b2b_accepts got=%0d exp=3", k); else passed++;
    if (k == 3) begin
      checks++; if (acc[1] - acc[0] !== 3) $display("FAIL b2b_gap1 got=%0d exp=3", acc[1] - acc[0]); else passed++;
      checks++; if (acc[2] - acc[1] !== 3) $display("FAIL b2b_gap2 got=%0d exp=3", acc[2] - acc[1]); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      checks++; if (v !== mregs[i]) $display("FAIL b2b_reg%0d got=%h exp=%h", i, v, mregs[i]); else passed++;
    end
    checks++; if ({bus.flag_c, bus.flag_z} !== {mc, mz}) $display("FAIL b2b_flags got=%b exp=%b", {bus.flag_c, bus.flag_z}, {mc, mz}); else passed++;
  endtask

  task automatic test_reset_midop();
    int lat; int seen; logic rdy; logic [3:0] a, b, v; logic [2:0] s; logic c;
    run_instr(mk_ldi(2, 7), lat, rdy, a, b, s, c); apply(mk_ldi(2, 7));
    read_reg(2, v);
    checks++; if (v !== 4'd7) $display("FAIL midrst_pre_r2 got=%h exp=7", v); else passed++;
    @(negedge clk);
    bus.instr = mk_alu(2, 2, 2, 0, 1);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL midrst_done got=%0d exp=0", seen); else passed++;
    checks++; if (bus.instr_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", bus.instr_ready); else passed++;
    read_reg(2, v);
    checks++; if (v !== 4'd0) $display("FAIL midrst_r2 got=%h exp=0", v); else passed++;
    checks++; if ({bus.flag_c, bus.flag_z} !== 2'b00) $display("FAIL midrst_flags got=%b exp=00", {bus.flag_c, bus.flag_z}); else passed++;
  endtask

  task automatic test_ignore_busy();
    logic [10:0] w;
    logic [3:0] v;
    logic r_exec, r_wb;
    run_instr(mk_ldi(0, 6), v, r_exec, v, v, w[2:0], r_wb);
    apply(mk_ldi(0, 6));
    w = mk_alu(1, 0, 0, 1, 1);
    @(negedge clk);
    bus.instr = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    apply(w);
    r_exec = bus.instr_ready;
    bus.instr = mk_ldi(3, 9);
    @(negedge clk);
    r_wb = bus.instr_ready;
    bus.instr = mk_ldi(0, 12);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    checks++; if ({r_exec, r_wb} !== 2'b00) $display("FAIL busy_ready got=%b exp=00", {r_exec, r_wb}); else passed++;
    checks++; if (bus.done !== 1'b1) $display("FAIL busy_done got=%b exp=1", bus.done); else passed++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      checks++; if (v !== mregs[i]) $display("FAIL busy_reg%0d got=%h exp=%h", i, v, mregs[i]); else passed++;
    end
    checks++; if ({bus.flag_c, bus.flag_z} !== {mc, mz}) $display("FAIL busy_flags got=%b exp=%b", {bus.flag_c, bus.flag_z}, {mc, mz}); else passed++;
  endtask

  task automatic test_random();
    int lat; logic rdy; logic [3:0] a, b, v; logic [2:0] s; logic c;
    logic [10:0] w;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 3) w = mk_ldi($urandom_range(0, 3), $urandom_range(0, 15));
      else w = mk_alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 7), $urandom_range(0, 1));
      run_instr(w, lat, rdy, a, b, s, c);
      checks++; if (lat !== (w[10] ? 1 : 2)) $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, lat, w[10] ? 1 : 2); else passed++;
      if (!w[10]) begin
        checks++;
        if ({a, b, s, c} !== {mregs[w[7:6]], mregs[w[5:4]], w[3:1], w[0]})
          $display("FAIL rnd%0d_drive got=%h exp=%h", it, {a, b, s, c}, {mregs[w[7:6]], mregs[w[5:4]], w[3:1], w[0]});
        else passed++;
      end
      apply(w);
      for (int i = 0; i < 4; i++) begin
        read_reg(i, v);
        checks++; if (v !== mregs[i]) $display("FAIL rnd%0d_reg%0d got=%h exp=%h", it, i, v, mregs[i]); else passed++;
      end
      checks++; if ({bus.flag_c, bus.flag_z} !== {mc, mz}) $display("FAIL rnd%0d_flags got=%b exp=%b", it, {bus.flag_c, bus.flag_z}, {mc, mz}); else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.dbg_addr = '0;
    test_reset();
    test_ldi();
    test_add();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    test_ignore_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
